// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer engine:
// FSM state encoding, width helpers and the fixed-point shift/saturate.
package fc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WRITE  = 3'd2,
      S_ARGMAX = 3'd3,
      S_DONE   = 3'd4
   } fc_state_t;

   localparam int DEF_DW   = 32;
   localparam int DEF_FRAC = 16;
   localparam int SAT_W    = 128;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Never returns zero so single-entry cases still get a legal port width.
   function automatic int clog2_min1(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Arithmetic right shift by frac, then clamp to the signed dw-bit range.
   function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                         input int dw, input int frac);
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      s  = acc >>> frac;
      hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (s > hi) begin
         return hi;
      end else if (s < lo) begin
         return lo;
      end else begin
         return s;
      end
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: wide accumulator with clear/enable and a combinational
// shift/saturate/ReLU view of the accumulated sum.
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int FRAC  = DEF_FRAC,
   parameter int ACC_W = 2*DEF_DW + 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 relu_en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] r
);

   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [SAT_W-1:0] sat_s;

   // Accumulator next value and the scaled, clamped output.
   always_comb begin
      prod_s = a * b;
      if (clr) begin
         acc_d = {ACC_W{1'b0}};
      end else if (en) begin
         acc_d = acc_q + ACC_W'(prod_s);
      end else begin
         acc_d = acc_q;
      end
      sat_s = sat_shift(SAT_W'(acc_q), DW, FRAC);
      if (relu_en && sat_s[SAT_W-1]) begin
         r = {DW{1'b0}};
      end else begin
         r = sat_s[DW-1:0];
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: LANES parallel dot products per pass over the
// streamed weights, optional ReLU, then a serial argmax over the results.
module fc_layer_engine
   import fc_pkg::*;
#(
   parameter int N_IN  = 784,
   parameter int N_OUT = 10,
   parameter int LANES = 2,
   parameter int DW    = DEF_DW,
   parameter int FRAC  = DEF_FRAC,
   localparam int G     = (N_OUT + LANES - 1) / LANES,
   localparam int AW    = clog2_min1(G * N_IN),
   localparam int CW    = clog2_min1(N_OUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  relu_en,
   input  logic [N_IN*DW-1:0]    in_vec,
   output logic                  w_req,
   output logic [AW-1:0]         w_addr,
   input  logic                  w_valid,
   input  logic [LANES*DW-1:0]   w_data,
   output logic                  busy,
   output logic                  done,
   output logic [N_OUT*DW-1:0]   result,
   output logic [CW-1:0]         class_idx
);

   localparam int IW    = clog2_min1(N_IN);
   localparam int GW    = clog2_min1(G);
   localparam int ACC_W = 2*DW + clog2(N_IN);

   fc_state_t state_q, state_d;
   logic [N_IN-1:0][DW-1:0]  in_buf_q, in_buf_d;
   logic [N_OUT-1:0][DW-1:0] result_q, result_d;
   logic                     relu_q, relu_d;
   logic [IW-1:0]            i_q, i_d;
   logic [GW-1:0]            g_q, g_d;
   logic [AW-1:0]            addr_q, addr_d;
   logic [CW-1:0]            k_q, k_d, best_q, best_d, class_q, class_d;
   logic signed [DW-1:0]     max_q, max_d, cand_s;
   logic                     w_req_q, w_req_d, busy_q, busy_d, done_q, done_d;
   logic                     xfer_s, last_i_s, last_g_s, last_k_s, clr_s, take_s;
   logic [LANES-1:0][DW-1:0] lane_r_s;

   // The address is a plain counter: g*N_IN+i advances by one per transfer.
   assign xfer_s   = (state_q == S_FETCH) && w_valid;
   assign last_i_s = (i_q == IW'(N_IN - 1));
   assign last_g_s = (g_q == GW'(G - 1));
   assign last_k_s = (k_q == CW'(N_OUT - 1));
   assign clr_s    = ((state_q == S_IDLE) && start) || (state_q == S_WRITE);
   assign cand_s   = $signed(result_q[k_q]);
   assign take_s   = (k_q == CW'(0)) || (cand_s > max_q);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fc_mac_lane #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr_s),
         .en      (xfer_s),
         .relu_en (relu_q),
         .a       (in_buf_q[i_q]),
         .b       (w_data[l*DW +: DW]),
         .r       (lane_r_s[l])
      );
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
         S_FETCH:  state_d = (xfer_s && last_i_s) ? S_WRITE : S_FETCH;
         S_WRITE:  state_d = last_g_s ? S_ARGMAX : S_FETCH;
         S_ARGMAX: state_d = last_k_s ? S_DONE : S_ARGMAX;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      in_buf_d = in_buf_q;
      result_d = result_q;
      relu_d   = relu_q;
      i_d      = i_q;
      g_d      = g_q;
      addr_d   = addr_q;
      k_d      = k_q;
      best_d   = best_q;
      max_d    = max_q;
      class_d  = class_q;
      w_req_d  = (state_d == S_FETCH);
      busy_d   = (state_d == S_FETCH) || (state_d == S_WRITE) || (state_d == S_ARGMAX);
      done_d   = (state_d == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               in_buf_d = in_vec;
               relu_d   = relu_en;
               i_d      = IW'(0);
               g_d      = GW'(0);
               addr_d   = AW'(0);
            end else begin
               in_buf_d = in_buf_q;
            end
         end
         S_FETCH: begin
            if (xfer_s) begin
               i_d    = i_q + IW'(1);
               addr_d = addr_q + AW'(1);
            end else begin
               i_d = i_q;
            end
         end
         S_WRITE: begin
            for (int l = 0; l < LANES; l++) begin
               if (int'(g_q) * LANES + l < N_OUT) begin
                  result_d[int'(g_q) * LANES + l] = lane_r_s[l];
               end else begin
                  result_d = result_d;
               end
            end
            i_d = IW'(0);
            k_d = CW'(0);
            if (!last_g_s) begin
               g_d = g_q + GW'(1);
            end else begin
               g_d = g_q;
            end
         end
         S_ARGMAX: begin
            if (take_s) begin
               max_d  = cand_s;
               best_d = k_q;
            end else begin
               max_d = max_q;
            end
            k_d = k_q + CW'(1);
            if (last_k_s) begin
               class_d = take_s ? k_q : best_q;
            end else begin
               class_d = class_q;
            end
         end
         S_DONE:  k_d = CW'(0);
         default: k_d = k_q;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_buf_q <= '0;
         result_q <= '0;
         relu_q   <= 1'b0;
         i_q      <= IW'(0);
         g_q      <= GW'(0);
         addr_q   <= AW'(0);
         k_q      <= CW'(0);
         best_q   <= CW'(0);
         max_q    <= DW'(0);
         class_q  <= CW'(0);
         w_req_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         in_buf_q <= in_buf_d;
         result_q <= result_d;
         relu_q   <= relu_d;
         i_q      <= i_d;
         g_q      <= g_d;
         addr_q   <= addr_d;
         k_q      <= k_d;
         best_q   <= best_d;
         max_q    <= max_d;
         class_q  <= class_d;
         w_req_q  <= w_req_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign w_req     = w_req_q;
   assign w_addr    = addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign class_idx = class_q;

endmodule
